load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_defs.sv | 27 ++
 rtl/lsu_lane_align.sv | 46 ++++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_defs.sv
// Shared encodings for the load/store unit: memory operation codes,
// read-modify-write FSM states and access sizes.
package lsu_defs;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MERGE = 2'd1,
        ST_WRITE = 2'd2
    } lsu_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian byte-lane extraction (loads) and lane merge (sub-word stores).
// Offset 0 addresses bits 31:24; sub-word store data arrives right-justified.
module lsu_lane_align
    import lsu_defs::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [2:0]  nbytes;
    logic [2:0]  lane_pos;
    logic [4:0]  shamt;
    logic [31:0] mask;
    logic [31:0] shifted;
    logic        sign_bit;

    always_comb begin
        nbytes   = 3'd4;
        mask     = 32'hFFFF_FFFF;
        sign_bit = 1'b0;
        if (size == SZ_BYTE) begin
            nbytes = 3'd1;
            mask   = 32'h0000_00FF;
        end else if (size == SZ_HALF) begin
            nbytes = 3'd2;
            mask   = 32'h0000_FFFF;
        end
        // Lane position counted from the least-significant byte of the word.
        lane_pos = 3'd4 - nbytes - {1'b0, offset};
        shamt    = {lane_pos[1:0], 3'b000};
        shifted  = old_word >> shamt;
        if (size == SZ_BYTE) begin
            sign_bit = shifted[7];
        end else if (size == SZ_HALF) begin
            sign_bit = shifted[15];
        end
        load_data   = (shifted & mask) | ((is_signed && sign_bit) ? ~mask : 32'h0);
        merged_word = (old_word & ~(mask << shamt)) | ((new_data & mask) << shamt);
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM stage: 1-cycle loads and word stores, a 3-cycle read-modify-write
// sequence for byte/halfword stores, alignment/window faults and MEM/WB regs.
module load_store_unit
    import lsu_defs::*;
#(
    parameter logic [31:0] WIN_BASE = 32'hFFFFFC00,
    parameter logic [31:0] WIN_MASK = 32'hFFFFFC00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd_in,
    input  logic        regwrite_in,
    input  logic [31:0] alu_in,
    output logic        stall,
    output logic [31:0] dm_addr,
    output logic        dm_we,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_regwrite,
    output logic [31:0] wb_data,
    output logic        fault,
    output logic [1:0]  fsm_state
);

    lsu_state_t  state, state_next;
    logic        is_mem, is_load, is_sw, is_rmw, is_signed;
    logic [1:0]  size, size_q, lane_size;
    logic        misaligned, out_win, bad, accept, start_rmw;
    logic [31:0] addr_q, wdata_q, alu_q, merge_q, eff_addr;
    logic [4:0]  rd_q;
    logic        regwrite_q;
    logic [31:0] load_data, merged_word;

    always_comb begin
        is_mem    = 1'b1;
        is_load   = 1'b0;
        is_sw     = 1'b0;
        is_rmw    = 1'b0;
        is_signed = 1'b0;
        size      = SZ_WORD;
        case (mem_op)
            OP_LB:   begin is_load = 1'b1; is_signed = 1'b1; size = SZ_BYTE; end
            OP_LBU:  begin is_load = 1'b1; size = SZ_BYTE; end
            OP_LH:   begin is_load = 1'b1; is_signed = 1'b1; size = SZ_HALF; end
            OP_LHU:  begin is_load = 1'b1; size = SZ_HALF; end
            OP_LW:   is_load = 1'b1;
            OP_SB:   begin is_rmw = 1'b1; size = SZ_BYTE; end
            OP_SH:   begin is_rmw = 1'b1; size = SZ_HALF; end
            OP_SW:   is_sw = 1'b1;
            default: is_mem = 1'b0;
        endcase
    end

    assign misaligned = ((size == SZ_HALF) && addr[0]) ||
                        ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    assign out_win    = (addr & WIN_MASK) != WIN_BASE;
    assign bad        = is_mem && (misaligned || out_win);

    // Handshake: an instruction is taken when req is high, mem_op is a memory
    // op and the FSM is idle. stall stays high from the SB/SH accept cycle
    // through WRITE; upstream holds its inputs during those cycles and may
    // present the next instruction right after the WRITE cycle.
    assign accept    = rst_n && req && is_mem && (state == ST_IDLE);
    assign start_rmw = accept && is_rmw && !bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start_rmw) state_next = ST_MERGE;
            ST_MERGE: state_next = ST_WRITE;
            ST_WRITE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        eff_addr  = (state == ST_IDLE) ? addr : addr_q;
        lane_size = (state == ST_IDLE) ? size : size_q;
        stall     = start_rmw || (state != ST_IDLE);
        dm_we     = (accept && is_sw && !bad) || (state == ST_WRITE);
        dm_wdata  = (state == ST_WRITE) ? merge_q : wdata;
        dm_addr   = {2'b11, eff_addr[31:2]};
    end

    assign fsm_state = state;

    lsu_lane_align u_lane_align (
        .offset      (eff_addr[1:0]),
        .size        (lane_size),
        .is_signed   (is_signed),
        .old_word    (dm_rdata),
        .new_data    (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= SZ_WORD;
            rd_q        <= '0;
            regwrite_q  <= 1'b0;
            alu_q       <= '0;
            merge_q     <= '0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_regwrite <= 1'b0;
            wb_data     <= '0;
            fault       <= 1'b0;
        end else begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            fault       <= 1'b0;
            // Writeback fields are captured at accept because upstream moves on after WRITE.
            if (start_rmw) begin
                addr_q     <= addr;
                wdata_q    <= wdata;
                size_q     <= size;
                rd_q       <= rd_in;
                regwrite_q <= regwrite_in;
                alu_q      <= alu_in;
            end
            if (state == ST_MERGE) begin
                merge_q <= merged_word;
            end
            if (accept && !start_rmw) begin
                wb_valid    <= 1'b1;
                wb_rd       <= rd_in;
                wb_regwrite <= regwrite_in && !bad;
                wb_data     <= (is_load && !bad) ? load_data : alu_in;
                fault       <= bad;
            end else if (state == ST_WRITE) begin
                wb_valid    <= 1'b1;
                wb_rd       <= rd_q;
                wb_regwrite <= regwrite_q;
                wb_data     <= alu_q;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table for single-cycle ops plus
// hand-written sequences for sub-word read-modify-write, reset and back-to-back.
module tb_load_store_unit;
    import lsu_defs::*;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [3:0]  mem_op;
    logic [31:0] addr, wdata, alu_in;
    logic [4:0]  rd_in;
    logic        regwrite_in;
    logic        stall;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_we;
    logic        wb_valid, wb_regwrite, fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  fsm_state;

    int n_cmp = 0;
    int n_bad = 0;
    int we_count = 0;
    int stray_we = 0;
    int wb_seen = 0;
    logic mon_en = 1'b0;
    logic [36:0] exp_q[$];
    logic [31:0] mem[256];

    load_store_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .mem_op      (mem_op),
        .addr        (addr),
        .wdata       (wdata),
        .rd_in       (rd_in),
        .regwrite_in (regwrite_in),
        .alu_in      (alu_in),
        .stall       (stall),
        .dm_addr     (dm_addr),
        .dm_we       (dm_we),
        .dm_wdata    (dm_wdata),
        .dm_rdata    (dm_rdata),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_regwrite (wb_regwrite),
        .wb_data     (wb_data),
        .fault       (fault),
        .fsm_state   (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // data memory: window words 0xFFFFFF00..0xFFFFFFFF
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[2]   = 32'h11223344;
        mem[255] = 32'hA5A50F0F;
    end
    assign dm_rdata = mem[dm_addr[7:0]];
    always @(posedge clk) begin
        if (dm_we) begin
            we_count <= we_count + 1;
            if (dm_addr[31:8] == 24'hFFFFFF) mem[dm_addr[7:0]] <= dm_wdata;
            else stray_we <= stray_we + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic r, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, input logic rw,
                         input logic [31:0] alu);
        req = r; mem_op = op; addr = a; wdata = wd; rd_in = rd; regwrite_in = rw; alu_in = alu;
    endtask

    task automatic idle_inputs();
        req = 1'b0; mem_op = OP_NONE; addr = 32'h0; wdata = 32'h0;
        rd_in = 5'd0; regwrite_in = 1'b0; alu_in = 32'h0;
    endtask

    typedef struct {
        logic        req;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] alu;
        logic        exp_we;
        logic        exp_valid;
        logic        exp_rw;
        logic        exp_fault;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NV = 17;
    vec_t vt[NV];

    function automatic vec_t mk(input logic r, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] wd, input logic [4:0] rd, input logic rw,
                                input logic [31:0] alu, input logic we, input logic v,
                                input logic erw, input logic f, input logic [31:0] d);
        vec_t x;
        x.req = r; x.op = op; x.addr = a; x.wdata = wd; x.rd = rd; x.rw = rw; x.alu = alu;
        x.exp_we = we; x.exp_valid = v; x.exp_rw = erw; x.exp_fault = f; x.exp_data = d;
        return x;
    endfunction

    task automatic fill_table();
        vt[0]  = mk(1, OP_SW,  32'hFFFFFC04, 32'hDEADBEEF, 5'd4,  0, 32'h00001111, 1, 1, 0, 0, 32'h00001111);
        vt[1]  = mk(1, OP_LW,  32'hFFFFFC04, 32'h0,        5'd5,  1, 32'h0,        0, 1, 1, 0, 32'hDEADBEEF);
        vt[2]  = mk(1, OP_LB,  32'hFFFFFC04, 32'h0,        5'd6,  1, 32'h0,        0, 1, 1, 0, 32'hFFFFFFDE);
        vt[3]  = mk(1, OP_LBU, 32'hFFFFFC04, 32'h0,        5'd7,  1, 32'h0,        0, 1, 1, 0, 32'h000000DE);
        vt[4]  = mk(1, OP_LH,  32'hFFFFFC06, 32'h0,        5'd8,  1, 32'h0,        0, 1, 1, 0, 32'hFFFFBEEF);
        vt[5]  = mk(1, OP_LHU, 32'hFFFFFC06, 32'h0,        5'd9,  1, 32'h0,        0, 1, 1, 0, 32'h0000BEEF);
        vt[6]  = mk(1, OP_LB,  32'hFFFFFC07, 32'h0,        5'd10, 1, 32'h0,        0, 1, 1, 0, 32'hFFFFFFEF);
        vt[7]  = mk(1, OP_LBU, 32'hFFFFFC05, 32'h0,        5'd11, 1, 32'h0,        0, 1, 1, 0, 32'h00000012);
        vt[8]  = mk(1, OP_SH,  32'hFFFFFC05, 32'h00005555, 5'd12, 1, 32'h00000077, 0, 1, 0, 1, 32'h00000077);
        vt[9]  = mk(1, OP_LW,  32'h00000000, 32'h0,        5'd13, 1, 32'h00000088, 0, 1, 0, 1, 32'h00000088);
        vt[10] = mk(1, OP_LW,  32'hFFFFFC02, 32'h0,        5'd14, 1, 32'h00000099, 0, 1, 0, 1, 32'h00000099);
        vt[11] = mk(1, OP_SW,  32'hFFFFFC01, 32'hFFFFFFFF, 5'd15, 0, 32'h000000AB, 0, 1, 0, 1, 32'h000000AB);
        vt[12] = mk(1, OP_SB,  32'h00000400, 32'h00000033, 5'd16, 1, 32'h000000CD, 0, 1, 0, 1, 32'h000000CD);
        vt[13] = mk(1, OP_NONE,32'hFFFFFC04, 32'h0,        5'd17, 1, 32'h00000001, 0, 0, 0, 0, 32'h0);
        vt[14] = mk(0, OP_SW,  32'hFFFFFC04, 32'h0BADF00D, 5'd18, 1, 32'h00000002, 0, 0, 0, 0, 32'h0);
        vt[15] = mk(1, OP_LW,  32'hFFFFFFFC, 32'h0,        5'd19, 1, 32'h0,        0, 1, 1, 0, 32'hA5A50F0F);
        vt[16] = mk(1, OP_LW,  32'hFFFFFBFC, 32'h0,        5'd20, 1, 32'h000000EE, 0, 1, 0, 1, 32'h000000EE);
    endtask

    task automatic apply_vec(input int i);
        vec_t v;
        v = vt[i];
        @(posedge clk); #1;
        drive(v.req, v.op, v.addr, v.wdata, v.rd, v.rw, v.alu);
        @(negedge clk);
        check($sformatf("v%0d stall", i), 32'(stall), 32'(1'b0));
        check($sformatf("v%0d dm_we", i), 32'(dm_we), 32'(v.exp_we));
        if (v.exp_we) check($sformatf("v%0d dm_wdata", i), dm_wdata, v.wdata);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'(v.exp_valid));
        if (v.exp_valid) begin
            check($sformatf("v%0d wb_data", i), wb_data, v.exp_data);
            check($sformatf("v%0d wb_regwrite", i), 32'(wb_regwrite), 32'(v.exp_rw));
            check($sformatf("v%0d fault", i), 32'(fault), 32'(v.exp_fault));
            check($sformatf("v%0d wb_rd", i), 32'(wb_rd), 32'(v.rd));
        end
    endtask

    // Holds the instruction while stall is high, releasing it after WRITE.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input logic rw, input logic [31:0] alu);
        int n;
        @(posedge clk); #1;
        drive(1'b1, op, a, wd, rd, rw, alu);
        @(negedge clk);
        if (stall) begin
            n = 0;
            while (fsm_state != ST_WRITE && n < 10) begin
                @(negedge clk);
                n++;
            end
            if (n >= 10) begin
                n_cmp++;
                n_bad++;
                $display("FAIL issue_timeout: got %0d cycles expected WRITE within 10", n);
            end
        end
    endtask

    // scoreboard for writeback order
    always @(negedge clk) begin
        if (mon_en && wb_valid) begin
            wb_seen++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wb_order: got %h expected no writeback", {wb_rd, wb_data});
            end else begin
                check("wb_order_data", wb_data, exp_q[0][31:0]);
                check("wb_order_rd", 32'(wb_rd), 32'(exp_q[0][36:32]));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int we_before;
        rst_n = 1'b0;
        idle_inputs();
        fill_table();
        repeat (2) @(negedge clk);
        check("rst stall", 32'(stall), 32'h0);
        check("rst dm_we", 32'(dm_we), 32'h0);
        check("rst wb_valid", 32'(wb_valid), 32'h0);
        check("rst wb_regwrite", 32'(wb_regwrite), 32'h0);
        check("rst fault", 32'(fault), 32'h0);
        check("rst wb_rd", 32'(wb_rd), 32'h0);
        check("rst wb_data", wb_data, 32'h0);
        check("rst state", 32'(fsm_state), 32'(ST_IDLE));
        rst_n = 1'b1;

        for (int i = 0; i < 2; i++) apply_vec(i);
        check("sw mem", mem[1], 32'hDEADBEEF);

        // SB 0x12 @0xFFFFFC05: accept, MERGE, WRITE all stalled
        @(posedge clk); #1;
        drive(1'b1, OP_SB, 32'hFFFFFC05, 32'hFFFFFF12, 5'd21, 1'b1, 32'h00000055);
        @(negedge clk);
        check("sb accept stall", 32'(stall), 32'h1);
        check("sb accept we", 32'(dm_we), 32'h0);
        @(negedge clk);
        check("sb merge stall", 32'(stall), 32'h1);
        check("sb merge state", 32'(fsm_state), 32'(ST_MERGE));
        check("sb merge we", 32'(dm_we), 32'h0);
        @(negedge clk);
        check("sb write stall", 32'(stall), 32'h1);
        check("sb write we", 32'(dm_we), 32'h1);
        check("sb write addr", dm_addr, 32'hFFFFFF01);
        check("sb write data", dm_wdata, 32'hDE12BEEF);
        check("sb write wb_valid", 32'(wb_valid), 32'h0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("sb done stall", 32'(stall), 32'h0);
        check("sb wb_valid", 32'(wb_valid), 32'h1);
        check("sb wb_data", wb_data, 32'h00000055);
        check("sb wb_rd", 32'(wb_rd), 32'd21);
        check("sb wb_regwrite", 32'(wb_regwrite), 32'h1);
        check("sb mem", mem[1], 32'hDE12BEEF);
        @(negedge clk);
        check("sb wb pulse", 32'(wb_valid), 32'h0);

        for (int i = 2; i < NV; i++) apply_vec(i);
        check("mem after faults", mem[1], 32'hDE12BEEF);
        check("stray writes", 32'(stray_we), 32'h0);

        // reset while SB 0xAA @0xFFFFFC08 is in MERGE
        we_before = we_count;
        @(posedge clk); #1;
        drive(1'b1, OP_SB, 32'hFFFFFC08, 32'h000000AA, 5'd22, 1'b1, 32'h0);
        @(negedge clk);
        check("rmw-rst accept stall", 32'(stall), 32'h1);
        @(negedge clk);
        check("rmw-rst in merge", 32'(fsm_state), 32'(ST_MERGE));
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check("rmw-rst state", 32'(fsm_state), 32'(ST_IDLE));
        check("rmw-rst stall", 32'(stall), 32'h0);
        check("rmw-rst dm_we", 32'(dm_we), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rmw-rst mem", mem[2], 32'h11223344);
        check("rmw-rst we count", 32'(we_count - we_before), 32'h0);

        // back-to-back SH, LW, SW with req held through stall
        we_before = we_count;
        wb_seen = 0;
        exp_q.push_back({5'd1, 32'h000000A1});
        exp_q.push_back({5'd2, 32'hCAFE3344});
        exp_q.push_back({5'd3, 32'h000000A3});
        mon_en = 1'b1;
        issue(OP_SH, 32'hFFFFFC08, 32'h0000CAFE, 5'd1, 1'b1, 32'h000000A1);
        issue(OP_LW, 32'hFFFFFC08, 32'h0,        5'd2, 1'b1, 32'h0);
        issue(OP_SW, 32'hFFFFFC0C, 32'h55667788, 5'd3, 1'b0, 32'h000000A3);
        @(posedge clk); #1;
        idle_inputs();
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        check("b2b wb count", 32'(wb_seen), 32'd3);
        check("b2b queue left", 32'(exp_q.size()), 32'd0);
        check("b2b we count", 32'(we_count - we_before), 32'd2);
        check("b2b sh mem", mem[2], 32'hCAFE3344);
        check("b2b sw mem", mem[3], 32'h55667788);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
